mem_series_checker: RTL and testbench

Bus initiator for the combinational-read / single-cycle-write data memory interface used throughout the core's test RAMs. On `start` it optionally fills a run of words with an arithmetic series (init + step·i), then reads the run back and compares each word, reporting pass/fail, a mismatch count and the first failing address. It sits in the test harness in place of the CPU data port: as a memory self-check, and to verify RAM preloads before a program runs.

---
 rtl/mem_series_checker.sv | 168 ++++++++++++++++
 tb/tb_mem_series_checker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_series_checker.sv
// Memory self-checker: optionally writes an arithmetic series into a run of words,
// then reads the run back and reports pass, mismatch count and first failing address.
module mem_series_checker #(
    parameter bit          BYTE_SWAP = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             check_only,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic [31:0]      init_value,
    input  logic [31:0]      step,
    output logic [31:0]      data_address,
    output logic             data_write,
    output logic             data_read,
    output logic [31:0]      data_writedata,
    input  logic [31:0]      data_readdata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [31:0]      first_err_addr
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    state_t           r_state;
    logic [31:0]      r_base;
    logic [31:0]      r_init;
    logic [31:0]      r_step;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_idx;
    logic [31:0]      r_value;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_wr;
    logic             r_rd;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_err;
    logic [31:0]      r_first;

    logic             w_last;
    logic [31:0]      w_next_value;
    logic [31:0]      w_expected;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_err_next;

    function automatic logic [31:0] f_swap(input logic [31:0] v);
        return BYTE_SWAP ? {v[7:0], v[15:8], v[23:16], v[31:24]} : v;
    endfunction

    assign w_last       = (r_idx == r_count - CNT_W'(1));
    assign w_next_value = r_value + r_step;
    assign w_expected   = f_swap(r_value);
    assign w_mismatch   = (data_readdata != w_expected);
    assign w_err_next   = (w_mismatch && (r_err != '1)) ? r_err + CNT_W'(1) : r_err;

    // Strobes, address and write data are registered and return to zero whenever idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_init  <= '0;
            r_step  <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_value <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_first <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= base_addr & 32'hFFFF_FFFC;
                        r_init  <= init_value;
                        r_step  <= step;
                        r_count <= word_count;
                        r_idx   <= '0;
                        r_value <= init_value;
                        r_err   <= '0;
                        r_first <= '0;
                        r_pass  <= 1'b0;
                        if (word_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else if (check_only) begin
                            r_state <= S_READ;
                            r_rd    <= 1'b1;
                            r_busy  <= 1'b1;
                            r_addr  <= base_addr & 32'hFFFF_FFFC;
                        end else begin
                            r_state <= S_WRITE;
                            r_wr    <= 1'b1;
                            r_busy  <= 1'b1;
                            r_addr  <= base_addr & 32'hFFFF_FFFC;
                            r_wdata <= f_swap(init_value);
                        end
                    end
                end
                S_WRITE: begin
                    if (w_last) begin
                        // Rewind to word 0 and read back with no bubble cycle.
                        r_state <= S_READ;
                        r_wr    <= 1'b0;
                        r_rd    <= 1'b1;
                        r_wdata <= '0;
                        r_addr  <= r_base;
                        r_value <= r_init;
                        r_idx   <= '0;
                    end else begin
                        r_addr  <= r_addr + 32'd4;
                        r_value <= w_next_value;
                        r_wdata <= f_swap(w_next_value);
                        r_idx   <= r_idx + CNT_W'(1);
                    end
                end
                S_READ: begin
                    r_err <= w_err_next;
                    if (w_mismatch && (r_err == '0)) begin
                        r_first <= r_addr;
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_rd    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_addr  <= '0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_addr  <= r_addr + 32'd4;
                        r_value <= w_next_value;
                        r_idx   <= r_idx + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_address   = r_addr;
    assign data_write     = r_wr;
    assign data_read      = r_rd;
    assign data_writedata = r_wdata;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_err_addr = r_first;

endmodule

// File: tb/tb_mem_series_checker.sv
// Directed bench for mem_series_checker: 64-word byte-reversed memory model,
// plus a narrow-counter instance driven with data that never matches.
module tb_mem_series_checker;

    logic        clk;
    logic        reset;
    logic        start;
    logic        check_only;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic [31:0] init_value;
    logic [31:0] step;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    logic        start2;
    logic [3:0]  word_count2;
    logic [31:0] addr2;
    logic        wr2;
    logic        rd2;
    logic [31:0] wdata2;
    logic [31:0] rdata2;
    logic        busy2;
    logic        done2;
    logic        pass2;
    logic [3:0]  err2;
    logic [31:0] first2;

    logic [31:0] mem [0:63];

    int          n_checks;
    int          n_pass;

    logic [31:0] wa [$];
    logic [31:0] wd [$];
    logic [31:0] ra [$];
    int          done_k;
    logic        bad_idle;
    logic        got_pass;
    logic [15:0] got_err;
    logic [31:0] got_first;

    mem_series_checker #(.BYTE_SWAP(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .check_only(check_only),
        .base_addr(base_addr), .word_count(word_count), .init_value(init_value), .step(step),
        .data_address(data_address), .data_write(data_write), .data_read(data_read),
        .data_writedata(data_writedata), .data_readdata(data_readdata),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
    );

    mem_series_checker #(.BYTE_SWAP(1'b1), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start2), .check_only(1'b1),
        .base_addr(32'h0000_0100), .word_count(word_count2), .init_value(32'h0), .step(32'h1),
        .data_address(addr2), .data_write(wr2), .data_read(rd2),
        .data_writedata(wdata2), .data_readdata(rdata2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_err_addr(first2)
    );

    assign data_readdata = mem[data_address[7:2]];
    assign rdata2        = 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Start a run in the next cycle and observe it cycle by cycle until done.
    task automatic run(input logic [31:0] base, input logic [15:0] n, input logic [31:0] init,
                       input logic [31:0] stp, input logic chk, input int corrupt_k, input logic noise);
        wa.delete(); wd.delete(); ra.delete();
        done_k = -1;
        bad_idle = 1'b0;
        @(negedge clk);
        base_addr = base; word_count = n; init_value = init; step = stp; check_only = chk;
        start = 1'b1;
        for (int k = 1; k <= 2 * int'(n) + 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (noise) begin
                start = (k % 2 == 0);
                base_addr = 32'h0; word_count = 16'd3; init_value = ~init; step = 32'h7; check_only = ~chk;
            end
            if (k == corrupt_k) mem[18] = mem[18] ^ 32'h0000_0001;
            if (data_write) begin
                wa.push_back(data_address);
                wd.push_back(data_writedata);
                mem[data_address[7:2]] = data_writedata;
            end
            if (data_read) ra.push_back(data_address);
            if ((data_write && data_read) || (!data_write && data_writedata != 32'h0) ||
                (!data_write && !data_read && data_address != 32'h0)) bad_idle = 1'b1;
            if (done) begin
                done_k = k;
                got_pass = pass;
                got_err = err_count;
                got_first = first_err_addr;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; check_only = 1'b0; base_addr = '0; word_count = '0;
        init_value = '0; step = '0; start2 = 1'b0; word_count2 = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        #1;
        n_checks++;
        if ({data_write, data_read, busy, done, pass} !== 5'b0) $display("FAIL reset_strobes got=%b exp=00000", {data_write, data_read, busy, done, pass});
        else n_pass++;
        n_checks++;
        if ({data_address, data_writedata, first_err_addr, err_count} !== 112'h0) $display("FAIL reset_buses addr=%h wdata=%h first=%h err=%0d exp=0", data_address, data_writedata, first_err_addr, err_count);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_check_only_preload;
        logic ok;
        for (int i = 0; i < 15; i++) mem[i] = bswap(32'h1234_5678 + 32'hDCBA_1234 * 32'(i));
        run(32'h0, 16'd15, 32'h1234_5678, 32'hDCBA_1234, 1'b1, 0, 1'b0);
        ok = (ra.size() == 15) && (wa.size() == 0);
        for (int i = 0; i < ra.size(); i++) if (ra[i] !== 32'(4 * i)) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL preload_reads got_reads=%0d got_writes=%0d exp=15/0 at 0x00..0x38", ra.size(), wa.size());
        else n_pass++;
        n_checks++;
        if (done_k !== 16) $display("FAIL preload_done_cycle got=%0d exp=16", done_k);
        else n_pass++;
        n_checks++;
        if ({got_pass, got_err} !== {1'b1, 16'd0}) $display("FAIL preload_result pass=%b err=%0d exp pass=1 err=0", got_pass, got_err);
        else n_pass++;
    endtask

    task automatic test_full_run;
        run(32'h40, 16'd4, 32'h0, 32'h1, 1'b0, 0, 1'b0);
        n_checks++;
        if (wa.size() != 4 || wa[0] !== 32'h40 || wa[1] !== 32'h44 || wa[2] !== 32'h48 || wa[3] !== 32'h4C)
            $display("FAIL full_write_addr got_n=%0d exp 0x40,0x44,0x48,0x4C", wa.size());
        else n_pass++;
        n_checks++;
        if (wd.size() != 4 || wd[0] !== 32'h0000_0000 || wd[1] !== 32'h0100_0000 || wd[2] !== 32'h0200_0000 || wd[3] !== 32'h0300_0000)
            $display("FAIL full_write_data got_n=%0d exp 00000000,01000000,02000000,03000000", wd.size());
        else n_pass++;
        n_checks++;
        if (ra.size() != 4 || ra[0] !== 32'h40 || ra[3] !== 32'h4C) $display("FAIL full_read_addr got_n=%0d exp 4 reads 0x40..0x4C", ra.size());
        else n_pass++;
        n_checks++;
        if (done_k !== 9 || got_pass !== 1'b1 || got_err !== 16'd0) $display("FAIL full_done done_k=%0d pass=%b err=%0d exp 9/1/0", done_k, got_pass, got_err);
        else n_pass++;
        n_checks++;
        if (bad_idle !== 1'b0) $display("FAIL full_bus_idle got=%b exp=0", bad_idle);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        run(32'h40, 16'd4, 32'h0, 32'h1, 1'b1, 0, 1'b0);
        n_checks++;
        if (done_k !== 5 || got_pass !== 1'b1 || ra.size() != 4 || wa.size() != 0)
            $display("FAIL b2b_check_only done_k=%0d pass=%b reads=%0d writes=%0d exp 5/1/4/0", done_k, got_pass, ra.size(), wa.size());
        else n_pass++;
    endtask

    task automatic test_corrupt;
        run(32'h40, 16'd4, 32'h0, 32'h1, 1'b0, 5, 1'b0);
        n_checks++;
        if ({got_pass, got_err, got_first} !== {1'b0, 16'd1, 32'h48})
            $display("FAIL corrupt_result pass=%b err=%0d first=%h exp 0/1/00000048", got_pass, got_err, got_first);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({done, pass, err_count, first_err_addr} !== {1'b0, 1'b0, 16'd1, 32'h48})
            $display("FAIL corrupt_hold done=%b pass=%b err=%0d first=%h exp 0/0/1/00000048", done, pass, err_count, first_err_addr);
        else n_pass++;
    endtask

    task automatic test_zero_len;
        run(32'h40, 16'd0, 32'h5, 32'h1, 1'b0, 0, 1'b0);
        n_checks++;
        if (done_k !== 1 || got_pass !== 1'b1 || got_err !== 16'd0 || got_first !== 32'h0 || wa.size() != 0 || ra.size() != 0)
            $display("FAIL zero_len done_k=%0d pass=%b err=%0d first=%h strobes=%0d exp 1/1/0/0/0", done_k, got_pass, got_err, got_first, wa.size() + ra.size());
        else n_pass++;
    endtask

    task automatic test_wrap;
        run(32'hFFFF_FFF9, 16'd4, 32'hA0, 32'h10, 1'b0, 0, 1'b0);
        n_checks++;
        if (wa.size() != 4 || wa[0] !== 32'hFFFF_FFF8 || wa[1] !== 32'hFFFF_FFFC || wa[2] !== 32'h0 || wa[3] !== 32'h4)
            $display("FAIL wrap_addr got_n=%0d exp FFFFFFF8,FFFFFFFC,00000000,00000004", wa.size());
        else n_pass++;
        n_checks++;
        if (ra.size() != 4 || ra[2] !== 32'h0 || done_k !== 9 || got_pass !== 1'b1)
            $display("FAIL wrap_read reads=%0d done_k=%0d pass=%b exp 4/9/1", ra.size(), done_k, got_pass);
        else n_pass++;
    endtask

    task automatic test_reset_midrun;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        base_addr = 32'h40; word_count = 16'd4; init_value = 32'h0; step = 32'h1; check_only = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({data_write, data_read, busy, done, data_address, data_writedata} !== 68'h0)
            $display("FAIL reset_async wr=%b rd=%b busy=%b done=%b addr=%h wdata=%h exp all 0", data_write, data_read, busy, done, data_address, data_writedata);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || data_write || data_read || busy) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL reset_no_resume got_activity=%b exp=0", seen);
        else n_pass++;
    endtask

    task automatic test_start_while_busy;
        run(32'h80, 16'd4, 32'h55, 32'h3, 1'b0, 0, 1'b1);
        n_checks++;
        if (wa.size() != 4 || wa[0] !== 32'h80 || wa[3] !== 32'h8C || wd[0] !== 32'h5500_0000 || wd[1] !== 32'h5800_0000 ||
            wd[2] !== 32'h5B00_0000 || wd[3] !== 32'h5E00_0000)
            $display("FAIL busy_start_writes got_n=%0d exp 4 writes 0x80..0x8C data 55/58/5B/5E000000", wa.size());
        else n_pass++;
        n_checks++;
        if (done_k !== 9 || got_pass !== 1'b1 || ra.size() != 4)
            $display("FAIL busy_start_done done_k=%0d pass=%b reads=%0d exp 9/1/4", done_k, got_pass, ra.size());
        else n_pass++;
    endtask

    task automatic test_saturate;
        int  dk;
        int  nrd;
        logic wr_seen;
        dk = -1; nrd = 0; wr_seen = 1'b0;
        @(negedge clk);
        word_count2 = 4'd15;
        start2 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (rd2) nrd++;
            if (wr2 || wdata2 != 32'h0) wr_seen = 1'b1;
            if (done2) begin
                dk = k;
                break;
            end
        end
        n_checks++;
        if (dk !== 16 || nrd != 15 || wr_seen !== 1'b0 || busy2 !== 1'b0)
            $display("FAIL sat_run done_k=%0d reads=%0d writes=%b busy=%b exp 16/15/0/0", dk, nrd, wr_seen, busy2);
        else n_pass++;
        n_checks++;
        if ({pass2, err2, first2, addr2} !== {1'b0, 4'd15, 32'h100, 32'h0})
            $display("FAIL sat_result pass=%b err=%0d first=%h addr=%h exp 0/15/00000100/0", pass2, err2, first2, addr2);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_check_only_preload();
        test_full_run();
        test_back_to_back();
        test_corrupt();
        test_zero_len();
        test_wrap();
        test_reset_midrun();
        test_start_while_busy();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
